// File: rtl/alu_trojan_pkg.sv
// Shared definitions for the trojan-ALU run-time monitor: op codes,
// monitor FSM states and the reference ALU model.
package alu_trojan_pkg;

  localparam int ALU_W = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    SUSPECT = 2'd1,
    ALARM   = 2'd2
  } mon_state_e;

  // Reference ALU; returns {cout, res}. For SUB, cout is the borrow (a < b).
  function automatic logic [ALU_W:0] golden_alu(input logic [ALU_W-1:0] a,
                                                input logic [ALU_W-1:0] b,
                                                input logic [1:0]       op);
    logic [ALU_W:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {(a < b), a - b};
      OP_AND:  r = {1'b0, a & b};
      default: r = {1'b0, a | b};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mismatch_log_fifo.sv
// Small synchronous FIFO holding the operands of mismatching transactions.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push into a full FIFO is dropped and latches the sticky ovf flag unless
// a pop frees a slot on the same edge.
module mismatch_log_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             push_ok, pop_ok;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  assign ovf     = ovf_q;

  // Next pointer / overflow state; clear empties the log and drops ovf.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
    ovf_d    = ovf_q | (push & full & ~pop_ok);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end
  end

  // Pointer and overflow flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage write; contents need no reset since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alu_trojan_monitor.sv
// Run-time checker for the 4-bit ADD/SUB/AND/OR ALU. Samples transactions
// into S1, compares against the reference ALU on the next edge (S2), counts
// mismatches, logs offending operands and escalates MONITOR->SUSPECT->ALARM.
module alu_trojan_monitor
  import alu_trojan_pkg::*;
#(
  parameter int WIDTH        = ALU_W,
  parameter int CNT_W        = 8,
  parameter int ALARM_THRESH = 3,
  parameter int LOG_DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [1:0]         in_op,
  input  logic [WIDTH-1:0]   in_res,
  input  logic               in_cout,
  input  logic               clear,
  input  logic               log_rd,
  output logic               mismatch,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               alarm,
  output logic               suspect,
  output logic               log_valid,
  output logic [2*WIDTH+1:0] log_data,
  output logic               log_full,
  output logic               log_ovf
);

  localparam int               ENTRY_W  = 2*WIDTH + 2;
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(ALARM_THRESH);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_res_q, s1_res_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic             s1_cout_q, s1_cout_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mon_state_e       state_q, state_d;
  logic             alarm_q, alarm_d, suspect_q, suspect_d;
  logic [WIDTH:0]   golden;
  logic             hit;
  logic             fifo_empty;

  // S1 capture: clear flushes the stage, ena only gates new samples.
  always_comb begin
    s1_valid_d = in_valid & ena & ~clear;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_res_d   = s1_res_q;
    s1_cout_d  = s1_cout_q;
    if (in_valid && ena) begin
      s1_a_d    = in_a;
      s1_b_d    = in_b;
      s1_op_d   = in_op;
      s1_res_d  = in_res;
      s1_cout_d = in_cout;
    end
  end

  // S1 pipeline flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_res_q   <= '0;
      s1_cout_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s1_res_q   <= s1_res_d;
      s1_cout_q  <= s1_cout_d;
    end
  end

  // Compare, count and next FSM state; a mismatch in flight at clear is dropped.
  always_comb begin
    golden     = golden_alu(s1_a_q, s1_b_q, s1_op_q);
    hit        = s1_valid_q & ~clear &
                 ({s1_res_q, s1_cout_q} != {golden[WIDTH-1:0], golden[WIDTH]});
    mismatch_d = hit;
    cnt_d      = cnt_q;
    state_d    = state_q;
    if (hit && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    if (clear) begin
      cnt_d   = '0;
      state_d = MONITOR;
    end else if (hit && state_q != ALARM) begin
      state_d = (cnt_d >= THRESH_C) ? ALARM : SUSPECT;
    end
    alarm_d   = (state_d == ALARM);
    suspect_d = (state_d == SUSPECT);
  end

  // S2: mismatch pulse and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      mismatch_q <= mismatch_d;
      cnt_q      <= cnt_d;
    end
  end

  // Threshold FSM with registered status outputs; ALARM is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MONITOR;
      alarm_q   <= 1'b0;
      suspect_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      alarm_q   <= alarm_d;
      suspect_q <= suspect_d;
    end
  end

  mismatch_log_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (hit),
    .pop   (log_rd),
    .clear (clear),
    .din   ({s1_op_q, s1_b_q, s1_a_q}),
    .dout  (log_data),
    .empty (fifo_empty),
    .full  (log_full),
    .ovf   (log_ovf)
  );

  assign mismatch  = mismatch_q;
  assign err_cnt   = cnt_q;
  assign alarm     = alarm_q;
  assign suspect   = suspect_q;
  assign log_valid = ~fifo_empty;

endmodule

// File: tb/tb_alu_trojan_monitor.sv
// Bench for alu_trojan_monitor: sampled transactions go into a scoreboard
// queue with their expected verdict; a behavioural model of counter, FSM and
// log is advanced on each edge and compared with the DUT every falling edge.
module tb_alu_trojan_monitor;

  localparam int DEPTH = 4;
  localparam int THR   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0, in_valid = 1'b0, in_cout = 1'b0, clear = 1'b0, log_rd = 1'b0;
  logic [3:0] in_a = '0, in_b = '0, in_res = '0;
  logic [1:0] in_op = '0;
  logic       mismatch, alarm, suspect, log_valid, log_full, log_ovf;
  logic [7:0] err_cnt;
  logic [9:0] log_data;

  alu_trojan_monitor dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_res(in_res),
    .in_cout(in_cout), .clear(clear), .log_rd(log_rd),
    .mismatch(mismatch), .err_cnt(err_cnt), .alarm(alarm),
    .suspect(suspect), .log_valid(log_valid), .log_data(log_data),
    .log_full(log_full), .log_ovf(log_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Independent reference: returns {cout, res}.
  function automatic logic [4:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
    logic [4:0] r;
    case (op)
      2'd0:    r = 5'(a) + 5'(b);
      2'd1:    r = {(a < b), 4'((a + 5'd16 - b) % 16)};
      2'd2:    r = {1'b0, a & b};
      default: r = {1'b0, a | b};
    endcase
    return r;
  endfunction

  typedef struct {
    logic       mis;
    logic [9:0] entry;
  } sb_t;

  sb_t        sb_q[$];
  logic [9:0] log_m[$];
  logic       s2_mis_m = 1'b0;
  int         cnt_m = 0;
  int         state_m = 0;  // 0 MONITOR, 1 SUSPECT, 2 ALARM
  logic       ovf_m = 1'b0;
  logic       chk_en = 1'b0;

  // Model update on each rising edge (or asynchronous reset).
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      sb_q.delete(); log_m.delete();
      s2_mis_m = 1'b0; cnt_m = 0; state_m = 0; ovf_m = 1'b0;
    end else begin
      sb_t        cur;
      logic       hit;
      logic [4:0] g;
      hit = 1'b0;
      cur.mis = 1'b0; cur.entry = '0;
      if (sb_q.size() > 0) begin
        cur = sb_q.pop_front();
        hit = cur.mis;
      end
      if (clear) begin
        log_m.delete();
        s2_mis_m = 1'b0; cnt_m = 0; state_m = 0; ovf_m = 1'b0;
      end else begin
        s2_mis_m = hit;
        if (log_rd && log_m.size() > 0) void'(log_m.pop_front());
        if (hit) begin
          if (cnt_m < 255) cnt_m++;
          if (state_m != 2) state_m = (cnt_m >= THR) ? 2 : 1;
          if (log_m.size() < DEPTH) log_m.push_back(cur.entry);
          else ovf_m = 1'b1;
        end
        if (in_valid && ena) begin
          sb_t nw;
          g = ref_alu(in_a, in_b, in_op);
          nw.mis   = ({in_cout, in_res} != g);
          nw.entry = {in_op, in_b, in_a};
          sb_q.push_back(nw);
        end
      end
    end
  end

  // Compare DUT with the model on every falling edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check_eq("mismatch", 32'(mismatch), 32'(s2_mis_m));
      check_eq("err_cnt", 32'(err_cnt), 32'(cnt_m));
      check_eq("alarm", 32'(alarm), 32'(state_m == 2));
      check_eq("suspect", 32'(suspect), 32'(state_m == 1));
      check_eq("log_valid", 32'(log_valid), 32'(log_m.size() > 0));
      check_eq("log_full", 32'(log_full), 32'(log_m.size() == DEPTH));
      check_eq("log_ovf", 32'(log_ovf), 32'(ovf_m));
      check_eq("log_data", 32'(log_data), (log_m.size() > 0) ? 32'(log_m[0]) : 32'd0);
    end
  end

  task automatic drive(input logic v, input logic en, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] op, input logic [3:0] res, input logic co,
                       input logic rd, input logic clr);
    @(negedge clk);
    in_valid = v; ena = en; in_a = a; in_b = b; in_op = op;
    in_res = res; in_cout = co; log_rd = rd; clear = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic txn_ok(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    logic [4:0] g;
    g = ref_alu(a, b, op);
    drive(1, 1, a, b, op, g[3:0], g[4], 0, 0);
  endtask

  task automatic txn_bad(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                         input logic rd);
    logic [4:0] g;
    g = ref_alu(a, b, op);
    drive(1, 1, a, b, op, g[3:0] ^ 4'h1, g[4], rd, 0);
  endtask

  task automatic do_clear();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"}, 32'({mismatch, err_cnt, alarm, suspect, log_valid,
                                  log_data, log_full, log_ovf}), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    idle(1);

    // 1. clean ADD
    drive(1, 1, 4'd5, 4'd3, 2'd0, 4'd8, 1'b0, 0, 0);
    idle(2);
    check_eq("t1_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("t1_suspect", 32'(suspect), 32'd0);

    // 2. ADD 15+15 reported as 15/0; pulse two edges after sampling
    drive(1, 1, 4'd15, 4'd15, 2'd0, 4'd15, 1'b0, 0, 0);
    idle(1);
    check_eq("t2_no_early_pulse", 32'(mismatch), 32'd0);
    idle(1);
    check_eq("t2_pulse", 32'(mismatch), 32'd1);
    check_eq("t2_err_cnt", 32'(err_cnt), 32'd1);
    check_eq("t2_suspect", 32'(suspect), 32'd1);
    check_eq("t2_log_data", 32'(log_data), 32'h0FF);

    // 3. two more mismatches -> alarm, held through clean traffic
    drive(1, 1, 4'd9, 4'd6, 2'd0, 4'd5, 1'b1, 0, 0);
    drive(1, 1, 4'd3, 4'd12, 2'd3, 4'd15, 1'b1, 0, 0);
    idle(2);
    check_eq("t3_err_cnt", 32'(err_cnt), 32'd3);
    check_eq("t3_alarm", 32'(alarm), 32'd1);
    for (int i = 0; i < 10; i++)
      txn_ok(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    idle(2);
    check_eq("t3_alarm_held", 32'(alarm), 32'd1);

    // ena=0 blocks sampling of a bad transaction
    drive(1, 0, 4'd1, 4'd1, 2'd0, 4'd0, 1'b0, 0, 0);
    idle(2);
    check_eq("ena_off_cnt", 32'(err_cnt), 32'd3);

    // 4. five back-to-back mismatches, no reads -> full + overflow
    do_clear();
    for (int i = 0; i < 5; i++) txn_bad(4'(i + 1), 4'(7 - i), 2'(i), 0);
    idle(2);
    check_eq("t4_err_cnt", 32'(err_cnt), 32'd5);
    check_eq("t4_full", 32'(log_full), 32'd1);
    check_eq("t4_ovf", 32'(log_ovf), 32'd1);
    check_eq("t4_head", 32'(log_data), 32'({2'd0, 4'd7, 4'd1}));
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    check_eq("t4_drained", 32'(log_valid), 32'd0);
    drive(0, 1, 0, 0, 0, 0, 0, 1, 0);  // read while empty: ignored
    idle(1);

    // Full + push + pop on the same edge: no overflow
    do_clear();
    for (int i = 0; i < 4; i++) txn_bad(4'(i), 4'(i + 8), 2'd2, 0);
    idle(2);
    txn_bad(4'd14, 4'd13, 2'd3, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    check_eq("fpp_ovf", 32'(log_ovf), 32'd0);
    check_eq("fpp_full", 32'(log_full), 32'd1);

    // Empty + push + pop: push wins
    do_clear();
    txn_bad(4'd2, 4'd2, 2'd0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    check_eq("epp_valid", 32'(log_valid), 32'd1);

    // 5. SUB borrow and AND cases
    do_clear();
    drive(1, 1, 4'd3, 4'd5, 2'd1, 4'd14, 1'b1, 0, 0);
    drive(1, 1, 4'd15, 4'd15, 2'd2, 4'd15, 1'b0, 0, 0);
    idle(2);
    check_eq("t5_clean_cnt", 32'(err_cnt), 32'd0);
    drive(1, 1, 4'd15, 4'd15, 2'd2, 4'd14, 1'b1, 0, 0);
    idle(2);
    check_eq("t5_and_bad", 32'(mismatch), 32'd1);

    // 6a. clear while a mismatch sits in S1 -> dropped
    txn_bad(4'd4, 4'd4, 2'd1, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    check_eq("t6_no_pulse", 32'(mismatch), 32'd0);
    check_eq("t6_cnt", 32'(err_cnt), 32'd0);
    check_eq("t6_log", 32'(log_valid), 32'd0);

    // 6b. reset mid-burst
    txn_bad(4'd1, 4'd2, 2'd0, 0);
    txn_bad(4'd3, 4'd4, 2'd1, 0);
    txn_bad(4'd5, 4'd6, 2'd3, 0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    idle(1);
    #2 rst_n = 1'b1;
    idle(3);
    check_all_zero("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
